// File: rtl/usb_sie_tx_if.sv
// ---------------------------------------------------------------------------
// usb_sie_tx_if : byte-wide TX port between the SIE transmitter and the
//                 USB transceiver (data/valid/ready, valid-low = EOP).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface usb_sie_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  // Packet source (SIE transmitter)
  modport master (output tx_data, output tx_valid, input tx_ready);
  // Packet sink (transceiver)
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

`default_nettype wire

// File: rtl/usb_sie_tx.sv
// ---------------------------------------------------------------------------
// usb_sie_tx : transmit half of the USB device SIE. Sends handshake packets
//              (PID only) and DATAx packets (PID, streamed payload, CRC16)
//              byte-wise into the transceiver TX port.
// Optional feature macro: USB_TX_IPG_EN (inter-packet gap of IPG_CYCLES).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module usb_sie_tx #(
  parameter int MAX_LEN    = 64,
  parameter int IPG_CYCLES = 8
) (
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic       pkt_start,
  input  wire logic [3:0] pkt_pid,
  input  wire logic       pkt_zlp,
  input  wire logic [7:0] pl_data,
  input  wire logic       pl_valid,
  input  wire logic       pl_last,
  output logic            pl_ready,
  usb_sie_tx_if.master    tx,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);

  // Elaboration-time sanity on the configuration.
  if (MAX_LEN < 1 || IPG_CYCLES < 1) begin : g_param_check
    $error("usb_sie_tx: MAX_LEN and IPG_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PID    = 3'd1,
    S_DATA   = 3'd2,
    S_CRC_LO = 3'd3,
    S_CRC_HI = 3'd4,
    S_GAP    = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [15:0]      crc_q, crc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             zlp_q, zlp_d;
  logic             is_data_q, is_data_d;

  logic             accept;
  logic             fetch_pt;
  logic             do_fetch;
  logic             do_finish;
  logic             do_abort;
  state_t           post_state;

`ifdef USB_TX_IPG_EN
  localparam int GAP_W = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
  logic [GAP_W-1:0] gap_q, gap_d;
`endif

  // CRC-16/USB, reflected polynomial, one byte LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Byte handshake and payload fetch qualification.
  always_comb begin
    accept   = valid_q & tx.tx_ready;
    fetch_pt = ((state_q == S_PID) && is_data_q && !zlp_q) ||
               ((state_q == S_DATA) && !last_q && (cnt_q != CNT_W'(MAX_LEN)));
    pl_ready = accept & fetch_pt & pl_valid;
    busy     = (state_q != S_IDLE);
  end

  assign tx.tx_data  = data_q;
  assign tx.tx_valid = valid_q;
  assign done        = done_q;
  assign err         = err_q;

  // Next-state and next-output decode.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    zlp_d     = zlp_q;
    is_data_d = is_data_q;
    do_fetch  = 1'b0;
    do_finish = 1'b0;
    do_abort  = 1'b0;
`ifdef USB_TX_IPG_EN
    gap_d      = gap_q;
    post_state = S_GAP;
`else
    post_state = S_IDLE;
`endif

    case (state_q)
      S_IDLE: begin
        if (pkt_start) begin
          if (pkt_pid[1]) begin
            // 2'b11 data, 2'b10 handshake
            state_d   = S_PID;
            data_d    = {~pkt_pid, pkt_pid};
            valid_d   = 1'b1;
            is_data_d = pkt_pid[0];
            zlp_d     = pkt_pid[0] & pkt_zlp;
            crc_d     = 16'hFFFF;
            cnt_d     = '0;
            last_d    = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_PID: begin
        if (accept) begin
          if (!is_data_q) begin
            do_finish = 1'b1;
          end else if (zlp_q) begin
            state_d = S_CRC_LO;
            data_d  = ~crc_q[7:0];
          end else begin
            do_fetch = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          if (last_q) begin
            state_d = S_CRC_LO;
            data_d  = ~crc_q[7:0];
          end else if (cnt_q == CNT_W'(MAX_LEN)) begin
            do_abort = 1'b1;
          end else begin
            do_fetch = 1'b1;
          end
        end
      end
      S_CRC_LO: begin
        if (accept) begin
          state_d = S_CRC_HI;
          data_d  = ~crc_q[15:8];
        end
      end
      S_CRC_HI: begin
        if (accept) do_finish = 1'b1;
      end
`ifdef USB_TX_IPG_EN
      S_GAP: begin
        if (gap_q == GAP_W'(IPG_CYCLES - 1)) begin
          state_d = S_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (do_fetch) begin
      if (pl_valid) begin
        state_d = S_DATA;
        data_d  = pl_data;
        crc_d   = crc16_byte(crc_q, pl_data);
        cnt_d   = cnt_q + 1'b1;
        last_d  = pl_last;
      end else begin
        do_abort = 1'b1;
      end
    end

    if (do_finish || do_abort) begin
      state_d = post_state;
      data_d  = 8'h00;
      valid_d = 1'b0;
      done_d  = do_finish;
      err_d   = do_abort;
      crc_d   = 16'hFFFF;
`ifdef USB_TX_IPG_EN
      gap_d   = '0;
`endif
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      crc_q     <= 16'hFFFF;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      zlp_q     <= 1'b0;
      is_data_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      err_q     <= err_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      zlp_q     <= zlp_d;
      is_data_q <= is_data_d;
    end
  end

`ifdef USB_TX_IPG_EN
  // Inter-packet gap counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) gap_q <= '0;
    else        gap_q <= gap_d;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_usb_sie_tx.sv
// ---------------------------------------------------------------------------
// tb_usb_sie_tx : directed bench for usb_sie_tx with an expected-byte queue.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_usb_sie_tx;
  localparam int MAX_LEN = 9;
  localparam int IPG     = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       pkt_start;
  logic [3:0] pkt_pid;
  logic       pkt_zlp;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_last;
  logic       pl_ready;
  logic       busy;
  logic       done;
  logic       err;

  usb_sie_tx_if txif ();

  usb_sie_tx #(.MAX_LEN(MAX_LEN), .IPG_CYCLES(IPG)) dut (
    .clk       (clk),
    .reset     (reset),
    .pkt_start (pkt_start),
    .pkt_pid   (pkt_pid),
    .pkt_zlp   (pkt_zlp),
    .pl_data   (pl_data),
    .pl_valid  (pl_valid),
    .pl_last   (pl_last),
    .pl_ready  (pl_ready),
    .tx        (txif),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] sb[$];
  logic [7:0] pl_mem[0:15];
  int         n_acc;
  int         n_done;
  int         n_err;
  bit         saw_plr;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_model(input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      c = c ^ {8'h00, pl_mem[k]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  task automatic push_data(input logic [3:0] pid, input int n);
    logic [15:0] c;
    sb.push_back({~pid, pid});
    for (int k = 0; k < n; k++) sb.push_back(pl_mem[k]);
    c = ~crc_model(n);
    sb.push_back(c[7:0]);
    sb.push_back(c[15:8]);
  endtask

  task automatic drive_pl(input int idx, input int avail, input int last_at);
    pl_valid = (idx < avail);
    pl_data  = (idx < 16) ? pl_mem[idx] : 8'h00;
    pl_last  = (idx == last_at);
  endtask

  // One packet request, run until done/err plus two tail cycles.
  task automatic run_pkt(input string tag, input logic [3:0] pid, input bit zlp,
                         input int avail, input int last_at, input bit toggle,
                         input int exp_done, input int exp_err);
    int idx, cyc, tail;
    bit consumed;
    idx = 0; cyc = 0; tail = 0;
    n_acc = 0; n_done = 0; n_err = 0; saw_plr = 1'b0;
    @(negedge clk);
    pkt_pid       = pid;
    pkt_zlp       = zlp;
    pkt_start     = 1'b1;
    txif.tx_ready = 1'b1;
    drive_pl(idx, avail, last_at);
    while (cyc < 200 && tail < 3) begin
      #1;
      consumed = pl_ready;
      if (pl_ready) saw_plr = 1'b1;
      if (txif.tx_valid) begin
        if (sb.size() > 0) check({tag, "_byte"}, {8'h00, txif.tx_data}, {8'h00, sb[0]});
        else               check({tag, "_extra"}, {15'h0, txif.tx_valid}, 16'h0);
        if (txif.tx_ready && sb.size() > 0) begin
          void'(sb.pop_front());
          n_acc++;
        end
      end
      if (done) n_done++;
      if (err)  n_err++;
      if (n_done + n_err > 0) tail++;
      @(negedge clk);
      cyc++;
      pkt_start = 1'b0;
      if (consumed) idx++;
      drive_pl(idx, avail, last_at);
      txif.tx_ready = toggle ? ~txif.tx_ready : 1'b1;
    end
    check({tag, "_timeout"}, {15'h0, (cyc >= 200)}, 16'h0);
    check({tag, "_left"}, 16'(sb.size()), 16'h0);
    check({tag, "_done"}, 16'(n_done), 16'(exp_done));
    check({tag, "_err"}, 16'(n_err), 16'(exp_err));
    sb.delete();
    pl_valid      = 1'b0;
    txif.tx_ready = 1'b1;
  endtask

  initial begin
    int w;
    reset = 1'b0; pkt_start = 1'b0; pkt_pid = 4'h0; pkt_zlp = 1'b0;
    pl_data = 8'h00; pl_valid = 1'b0; pl_last = 1'b0; txif.tx_ready = 1'b1;
    #12;
    check("rst_tx_valid", {15'h0, txif.tx_valid}, 16'h0);
    check("rst_tx_data", {8'h0, txif.tx_data}, 16'h0);
    check("rst_busy", {15'h0, busy}, 16'h0);
    check("rst_done", {15'h0, done}, 16'h0);
    check("rst_err", {15'h0, err}, 16'h0);
    check("rst_pl_ready", {15'h0, pl_ready}, 16'h0);
    @(negedge clk); reset = 1'b1;

    // ACK handshake
    sb.push_back(8'hD2);
    run_pkt("ack", 4'h2, 1'b0, 0, -1, 1'b0, 1, 0);
    check("ack_bytes", 16'(n_acc), 16'd1);
    check("ack_pl_ready", {15'h0, saw_plr}, 16'h0);
`ifndef USB_TX_IPG_EN
    check("ack_idle_busy", {15'h0, busy}, 16'h0);
`endif

    // DATA1 "123456789", exactly MAX_LEN bytes
    for (int k = 0; k < 9; k++) pl_mem[k] = 8'h31 + 8'(k);
    sb.push_back(8'h4B);
    for (int k = 0; k < 9; k++) sb.push_back(pl_mem[k]);
    sb.push_back(8'hC8); sb.push_back(8'hB4);
    run_pkt("data1", 4'hB, 1'b0, 9, 8, 1'b0, 1, 0);
    check("data1_bytes", 16'(n_acc), 16'd12);

    // DATA0 zero-length
    sb.push_back(8'hC3); sb.push_back(8'h00); sb.push_back(8'h00);
    run_pkt("zlp", 4'h3, 1'b1, 4, 3, 1'b0, 1, 0);
    check("zlp_pl_ready", {15'h0, saw_plr}, 16'h0);

    // DATA0 with toggling backpressure
    for (int k = 0; k < 5; k++) pl_mem[k] = 8'($urandom_range(0, 255));
    push_data(4'h3, 5);
    run_pkt("bp", 4'h3, 1'b0, 5, 4, 1'b1, 1, 0);

    // Underrun after two payload bytes
    sb.push_back(8'h4B); sb.push_back(pl_mem[0]); sb.push_back(pl_mem[1]);
    run_pkt("under", 4'hB, 1'b0, 2, -1, 1'b0, 0, 1);

    // NAK right after an abort
    sb.push_back(8'h5A);
    run_pkt("nak", 4'hA, 1'b0, 0, -1, 1'b0, 1, 0);

    // Overrun: stream longer than MAX_LEN without last
    for (int k = 0; k < 11; k++) pl_mem[k] = 8'hA0 + 8'(k);
    sb.push_back(8'hC3);
    for (int k = 0; k < MAX_LEN; k++) sb.push_back(pl_mem[k]);
    run_pkt("over", 4'h3, 1'b0, 11, -1, 1'b0, 0, 1);

    // Reserved PID class rejected
    run_pkt("reject", 4'h1, 1'b0, 0, -1, 1'b0, 0, 1);

    // Asynchronous reset in the middle of a payload
    @(negedge clk);
    pkt_pid = 4'hB; pkt_zlp = 1'b0; pkt_start = 1'b1;
    pl_valid = 1'b1; pl_data = 8'h55; pl_last = 1'b0;
    @(negedge clk); pkt_start = 1'b0;
    repeat (2) @(negedge clk);
    check("arst_pre_valid", {15'h0, txif.tx_valid}, 16'h1);
    #2 reset = 1'b0;
    #1;
    check("arst_tx_valid", {15'h0, txif.tx_valid}, 16'h0);
    check("arst_tx_data", {8'h0, txif.tx_data}, 16'h0);
    check("arst_busy", {15'h0, busy}, 16'h0);
    check("arst_pl_ready", {15'h0, pl_ready}, 16'h0);
    check("arst_done_err", {14'h0, done, err}, 16'h0);
    @(negedge clk); reset = 1'b1; pl_valid = 1'b0;

`ifdef USB_TX_IPG_EN
    // Start during the inter-packet gap is ignored
    sb.push_back(8'hD2);
    run_pkt("gap_ack", 4'h2, 1'b0, 0, -1, 1'b0, 1, 0);
    @(negedge clk); pkt_pid = 4'h2; pkt_start = 1'b1;
    #1 check("gap_busy", {15'h0, busy}, 16'h1);
    @(negedge clk); pkt_start = 1'b0;
    #1 check("gap_no_tx", {15'h0, txif.tx_valid}, 16'h0);
    w = 0;
    while (busy && w < 50) begin @(negedge clk); w++; end
    check("gap_end", {15'h0, busy}, 16'h0);
    check("gap_quiet", {14'h0, txif.tx_valid, done}, 16'h0);
`else
    w = 0;
`endif

    // Normal packet after reset
    for (int k = 0; k < 3; k++) pl_mem[k] = 8'h10 + 8'(k);
    push_data(4'hB, 3);
    run_pkt("post", 4'hB, 1'b0, 3, 2, 1'b0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
